// File: rtl/lsu_pkg.sv
// Shared encodings, widths and lane helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned LANES  = XLEN / LANE_W;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_SW  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101,
    OP_SB  = 3'b110,
    OP_SH  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  localparam logic [LANES-1:0] BE_BYTE    = 4'b0001;
  localparam logic [LANES-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [LANES-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [LANES-1:0] BE_WORD    = 4'b1111;

  function automatic logic is_store(input op_e op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic logic is_half(input op_e op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic misaligned(input op_e op, input logic [1:0] off);
    return (is_half(op) && off[0]) || (is_word(op) && (off != 2'b00));
  endfunction

  function automatic logic [LANES-1:0] byte_en(input op_e op, input logic [1:0] off);
    if (is_word(op)) return BE_WORD;
    if (is_half(op)) return off[1] ? BE_HALF_HI : BE_HALF_LO;
    return BE_BYTE << off;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store replication and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  op_e              st_op,
  input  logic [XLEN-1:0]  st_data,
  input  op_e              ld_op,
  input  logic [1:0]       ld_off,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  wdata_c,
  output logic [XLEN-1:0]  ld_data_c
);

  logic [LANE_W-1:0]   byte_sel;
  logic [2*LANE_W-1:0] half_sel;

  always_comb begin
    byte_sel = rdata[{ld_off, 3'b000} +: LANE_W];
    half_sel = ld_off[1] ? rdata[XLEN-1:2*LANE_W] : rdata[2*LANE_W-1:0];
    case (ld_op)
      OP_LB:   ld_data_c = {{(XLEN-LANE_W){byte_sel[LANE_W-1]}}, byte_sel};
      OP_LBU:  ld_data_c = {{(XLEN-LANE_W){1'b0}}, byte_sel};
      OP_LH:   ld_data_c = {{(XLEN-2*LANE_W){half_sel[2*LANE_W-1]}}, half_sel};
      OP_LHU:  ld_data_c = {{(XLEN-2*LANE_W){1'b0}}, half_sel};
      default: ld_data_c = rdata;
    endcase
  end

  // Narrow stores are replicated so every enabled lane sees the right bytes.
  always_comb begin
    case (st_op)
      OP_SB:   wdata_c = {LANES{st_data[LANE_W-1:0]}};
      OP_SH:   wdata_c = {(LANES/2){st_data[2*LANE_W-1:0]}};
      default: wdata_c = st_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: address add, alignment check, req/ack bus FSM
// with timeout, registered results and error pulses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   base,
  input  logic [XLEN-1:0]   ext_imm,
  input  logic [XLEN-1:0]   store_data,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   load_data,
  output logic              addr_err,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [LANES-1:0]  mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  state_e             state;
  op_e                op_q;
  logic [1:0]         off_q;
  logic [CNT_W-1:0]   cnt;
  op_e                op_in;
  logic [XLEN-1:0]    ea_c;
  logic [XLEN-1:0]    wdata_c;
  logic [XLEN-1:0]    ld_data_c;

  assign op_in = op_e'(op);
  assign ea_c  = base + ext_imm;

  lsu_align u_align (
    .st_op     (op_in),
    .st_data   (store_data),
    .ld_op     (op_q),
    .ld_off    (off_q),
    .rdata     (mem_rdata),
    .wdata_c   (wdata_c),
    .ld_data_c (ld_data_c)
  );

  // Bus timeout is routed through ERR so busy covers the bus_err cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_LB;
      off_q     <= 2'b00;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      load_data <= '0;
      addr_err  <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op_in;
            off_q <= ea_c[1:0];
            busy  <= 1'b1;
            if (misaligned(op_in, ea_c[1:0])) begin
              addr_err <= 1'b1;
              state    <= S_ERR;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store(op_in);
              mem_addr  <= {ea_c[XLEN-1:2], 2'b00};
              mem_be    <= byte_en(op_in, ea_c[1:0]);
              mem_wdata <= is_store(op_in) ? wdata_c : '0;
              cnt       <= CNT_W'(1);
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            cnt     <= '0;
            if (!is_store(op_q)) load_data <= ld_data_c;
            state   <= S_DONE;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            cnt     <= '0;
            state   <= S_ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          addr_err <= 1'b0;
          bus_err  <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with an arithmetic reference model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] base = '0, ext_imm = '0, store_data = '0;
  logic        busy, done, addr_err, bus_err, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [2:0]  kind;   // {done, addr_err, bus_err}
    logic [31:0] data;
    int          lat;
  } resp_t;

  req_t  exp_req[$];
  resp_t exp_resp[$];
  req_t  cur;
  int    total = 0, bad = 0;
  logic [31:0] ref_load = '0;
  logic [31:0] rsp_word = '0;
  int    rsp_ack_at = 0;
  int    rcyc = 0;
  int    lat = 0;
  logic  prev_req = 1'b0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .base(base), .ext_imm(ext_imm),
    .store_data(store_data), .busy(busy), .done(done), .load_data(load_data),
    .addr_err(addr_err), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks in REQ cycle rsp_ack_at (0 = never), random ack noise when idle.
  always begin
    @(posedge clk);
    #1;
    if (mem_req) begin
      rcyc++;
      mem_ack   = (rcyc == rsp_ack_at);
      mem_rdata = (rcyc == rsp_ack_at) ? rsp_word : $urandom;
    end else begin
      rcyc      = 0;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  // Monitor: pops expected bus requests and responses as the DUT presents them.
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
      lat = 0;
    end else begin
      lat = busy ? lat + 1 : 0;
      if (mem_req && !prev_req) begin
        if (exp_req.size() == 0) chk("unexpected_req", 32'(mem_req), 32'd0);
        else cur = exp_req.pop_front();
      end
      if (mem_req) begin
        chk("req_addr", mem_addr, cur.addr);
        chk("req_we", 32'(mem_we), 32'(cur.we));
        chk("req_be", 32'(mem_be), 32'(cur.be));
        if (cur.we) chk("req_wdata", mem_wdata, cur.wdata);
      end
      if (done || addr_err || bus_err) begin
        if (exp_resp.size() == 0) begin
          chk("unexpected_resp", 32'({done, addr_err, bus_err}), 32'd0);
        end else begin
          resp_t rs;
          rs = exp_resp.pop_front();
          chk("resp_kind", 32'({done, addr_err, bus_err}), 32'(rs.kind));
          chk("resp_latency", 32'(lat), 32'(rs.lat));
          chk("load_data", load_data, rs.data);
        end
      end
      prev_req = mem_req;
    end
  end

  // Reference model: predicts the bus request and response from the ISA-level rules.
  task automatic launch(input logic [2:0] o, input logic [31:0] b, input logic [31:0] im,
                        input logic [31:0] sd, input logic [31:0] word, input int ack_at);
    logic [31:0] ea;
    int          size;
    bit          st;
    longint      raw;
    req_t        rq;
    resp_t       rs;
    ea   = b + im;
    size = (o == 0 || o == 4 || o == 6) ? 1 : (o == 1 || o == 5 || o == 7) ? 2 : 4;
    st   = (o == 3 || o == 6 || o == 7);
    if ((ea % size) != 0) begin
      rs.kind = 3'b010;
      rs.lat  = 1;
    end else begin
      rq.addr  = ea - (ea % 4);
      rq.we    = st;
      rq.be    = 4'(((1 << size) - 1) << (ea % 4));
      rq.wdata = (size == 1) ? (sd % 256) * 32'h01010101 :
                 (size == 2) ? (sd % 65536) * 32'h00010001 : sd;
      exp_req.push_back(rq);
      if (ack_at >= 1 && ack_at <= TO) begin
        rs.kind = 3'b100;
        rs.lat  = ack_at + 1;
        if (!st) begin
          raw = (longint'(word) >> (8 * (ea % 4))) % (longint'(1) << (8 * size));
          if ((o == 0 || o == 1) && raw >= (longint'(1) << (8 * size - 1)))
            raw -= (longint'(1) << (8 * size));
          ref_load = 32'(raw);
        end
      end else begin
        rs.kind = 3'b001;
        rs.lat  = TO + 1;
      end
    end
    rs.data = ref_load;
    exp_resp.push_back(rs);
    rsp_word   = word;
    rsp_ack_at = ack_at;
    op = o; base = b; ext_imm = im; store_data = sd; start = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs and re-strobe while busy; the unit must ignore all of it.
    start = 1'($urandom_range(0, 1));
    op = 3'($urandom); base = $urandom; ext_imm = $urandom; store_data = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("idle_wait", 32'(ok), 32'd1);
  endtask

  task automatic txn(input logic [2:0] o, input logic [31:0] b, input logic [31:0] im,
                     input logic [31:0] sd, input logic [31:0] word, input int ack_at);
    launch(o, b, im, sd, word, ack_at);
    wait_idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_load_data"}, load_data, 32'd0);
    chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    txn(3'b000, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0, 32'h80AA_BBCC, 1);  // LB
    txn(3'b100, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0, 32'h80AA_BBCC, 1);  // LBU
    txn(3'b111, 32'h0000_2000, 32'h0000_0002, 32'h1234_ABCD, 32'h0, 4);  // SH, 3 waits
    txn(3'b010, 32'h0000_2000, 32'h0000_0001, 32'h0, 32'h0, 1);          // LW misaligned
    txn(3'b001, 32'h0000_3000, 32'h0000_0003, 32'h0, 32'h0, 1);          // LH misaligned
    txn(3'b010, 32'h0000_4000, 32'h0000_0010, 32'h0, 32'h0, 0);          // LW timeout
    txn(3'b010, 32'h0000_4000, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 2);  // LW after timeout
    txn(3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0, 32'h1357_9BDF, 1);  // wrap
    txn(3'b101, 32'h0000_0100, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 3);  // LHU upper
    txn(3'b001, 32'h0000_0100, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 2);  // LH upper
    txn(3'b110, 32'h0000_0200, 32'h0000_0001, 32'hFFFF_FF5A, 32'h0, 1);  // SB lane 1
    txn(3'b011, 32'h0000_0200, 32'h0000_0004, 32'hCAFE_F00D, 32'h0, 5);  // SW timeout

    // Reset mid-REQ: request drops asynchronously, transaction is abandoned
    launch(3'b010, 32'h0000_5000, 32'h0, 32'h0, 32'h0, 0);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk_all_zero("mid_req_reset");
    exp_resp.delete();
    exp_req.delete();
    ref_load = '0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    txn(3'b010, 32'h0000_6000, 32'h0000_0004, 32'h0, 32'h0BAD_F00D, 1);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      logic [31:0] b, im;
      b  = $urandom;
      im = $urandom;
      if ($urandom_range(0, 3) != 0) b = b - ((b + im) % 4);
      txn(3'($urandom), b, im, $urandom, $urandom, $urandom_range(1, 6));
    end

    repeat (5) @(posedge clk);
    chk("pending_resp", 32'(exp_resp.size()), 32'd0);
    chk("pending_req", 32'(exp_req.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
